// File: rtl/future_round_ctrl_if.sv
// Control bundle between the FUTURE round controller and the cipher wrapper/datapath.
// The master side is the wrapper; the slave side is the round controller.
interface future_round_ctrl_if #(
   parameter int CW = 4
);
   logic          start;
   logic          abort;
   logic          ack;
   logic          sel;
   logic          reg_en;
   logic          key_en;
   logic [CW-1:0] round;
   logic          last;
   logic          busy;
   logic          done;

   modport master (
      output start,
      output abort,
      output ack,
      input  sel,
      input  reg_en,
      input  key_en,
      input  round,
      input  last,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  abort,
      input  ack,
      output sel,
      output reg_en,
      output key_en,
      output round,
      output last,
      output busy,
      output done
   );
endinterface

// File: rtl/future_round_ctrl.sv
// Round controller for the FUTURE cipher: sequences one block through whitening
// plus ROUNDS rounds and drives the state-input mux select and datapath enables.
module future_round_ctrl #(
   parameter int ROUNDS = 10,
   parameter int CW     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   future_round_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS);
   localparam logic [CW-1:0] FIRST_ROUND = CW'(1);

   state_t        r_state;
   logic          r_sel;
   logic          r_reg_en;
   logic          r_key_en;
   logic [CW-1:0] r_round;
   logic          r_last;
   logic          r_busy;
   logic          r_done;

   logic [CW-1:0] w_round_inc;

   assign w_round_inc = r_round + FIRST_ROUND;

   // Every output is a register written alongside the state, so nothing on the
   // wrapper side ever sees a combinational path from start/abort/ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_sel    <= 1'b0;
         r_reg_en <= 1'b0;
         r_key_en <= 1'b0;
         r_round  <= '0;
         r_last   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state  <= S_LOAD;
                  r_sel    <= 1'b1;
                  r_reg_en <= 1'b1;
                  r_key_en <= 1'b0;
                  r_round  <= '0;
                  r_last   <= 1'b0;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
               end
            end

            S_LOAD: begin
               if (bus.abort) begin
                  r_state  <= S_IDLE;
                  r_sel    <= 1'b0;
                  r_reg_en <= 1'b0;
                  r_key_en <= 1'b0;
                  r_round  <= '0;
                  r_last   <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b0;
               end else begin
                  r_state  <= S_ROUND;
                  r_sel    <= 1'b0;
                  r_reg_en <= 1'b1;
                  r_key_en <= 1'b1;
                  r_round  <= FIRST_ROUND;
                  r_last   <= (FIRST_ROUND == LAST_ROUND);
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
               end
            end

            S_ROUND: begin
               if (bus.abort) begin
                  r_state  <= S_IDLE;
                  r_sel    <= 1'b0;
                  r_reg_en <= 1'b0;
                  r_key_en <= 1'b0;
                  r_round  <= '0;
                  r_last   <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b0;
               end else if (r_round == LAST_ROUND) begin
                  // Round index freezes at ROUNDS while the result is held.
                  r_state  <= S_DONE;
                  r_sel    <= 1'b0;
                  r_reg_en <= 1'b0;
                  r_key_en <= 1'b0;
                  r_last   <= 1'b0;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b1;
               end else begin
                  r_round  <= w_round_inc;
                  r_last   <= (w_round_inc == LAST_ROUND);
               end
            end

            S_DONE: begin
               if (bus.abort) begin
                  r_state  <= S_IDLE;
                  r_sel    <= 1'b0;
                  r_reg_en <= 1'b0;
                  r_key_en <= 1'b0;
                  r_round  <= '0;
                  r_last   <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b0;
               end else if (bus.ack && bus.start) begin
                  // Back-to-back block: skip IDLE and reload straight away.
                  r_state  <= S_LOAD;
                  r_sel    <= 1'b1;
                  r_reg_en <= 1'b1;
                  r_key_en <= 1'b0;
                  r_round  <= '0;
                  r_last   <= 1'b0;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
               end else if (bus.ack) begin
                  r_state  <= S_IDLE;
                  r_sel    <= 1'b0;
                  r_reg_en <= 1'b0;
                  r_key_en <= 1'b0;
                  r_round  <= '0;
                  r_last   <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b0;
               end
            end

            default: begin
               r_state  <= S_IDLE;
               r_sel    <= 1'b0;
               r_reg_en <= 1'b0;
               r_key_en <= 1'b0;
               r_round  <= '0;
               r_last   <= 1'b0;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sel    = r_sel;
   assign bus.reg_en = r_reg_en;
   assign bus.key_en = r_key_en;
   assign bus.round  = r_round;
   assign bus.last   = r_last;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;

endmodule

// File: tb/tb_future_round_ctrl.sv
// Self-checking bench for future_round_ctrl: a block-position model is compared
// against the DUT every cycle, plus directed checks with hand-computed values.
module tb_future_round_ctrl;

   localparam int ROUNDS = 10;
   localparam int CW     = 4;

   logic clk;
   logic rst_n;

   future_round_ctrl_if #(.CW(CW)) bus ();

   future_round_ctrl #(.ROUNDS(ROUNDS), .CW(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nTests = 0;
   int nFail  = 0;
   bit cmpEn  = 1'b0;

   logic [9:0] dutVec;
   assign dutVec = {bus.sel, bus.reg_en, bus.key_en, bus.round, bus.last, bus.busy, bus.done};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Model: a block is either absent or at position mPos, where 0 is the load
   // cycle, 1..ROUNDS are the rounds and ROUNDS+1 means the result is held.
   bit mActive = 1'b0;
   int mPos    = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mActive = 1'b0;
         mPos    = 0;
      end else if (mActive && bus.abort) begin
         mActive = 1'b0;
         mPos    = 0;
      end else if (!mActive) begin
         if (bus.start) begin
            mActive = 1'b1;
            mPos    = 0;
         end
      end else if (mPos <= ROUNDS) begin
         mPos = mPos + 1;
      end else if (bus.ack) begin
         if (bus.start) mPos = 0;
         else mActive = 1'b0;
      end
   end

   function automatic logic [9:0] modelVec();
      logic [CW-1:0] r;
      if (!mActive) return '0;
      r = (mPos > ROUNDS) ? CW'(ROUNDS) : CW'(mPos);
      return {mPos == 0, mPos <= ROUNDS, (mPos >= 1) && (mPos <= ROUNDS), r,
              mPos == ROUNDS, 1'b1, mPos == ROUNDS + 1};
   endfunction

   always @(posedge clk) begin
      #2;
      if (cmpEn) checkOutput("cycle_vs_model", dutVec, modelVec());
   end

   // Per-block activity counters taken from the DUT outputs.
   int regEnCnt = 0;
   int keyEnCnt = 0;
   int selCnt   = 0;
   int doneRise = 0;
   logic prevDone = 1'b0;

   always @(posedge clk) begin
      #1;
      if (bus.reg_en === 1'b1) regEnCnt++;
      if (bus.key_en === 1'b1) keyEnCnt++;
      if (bus.sel === 1'b1) selCnt++;
      if (bus.done === 1'b1 && prevDone !== 1'b1) doneRise++;
      prevDone = bus.done;
   end

   task automatic clearCounts();
      regEnCnt = 0;
      keyEnCnt = 0;
      selCnt   = 0;
      doneRise = 0;
   endtask

   task automatic applyStimulus(input logic s, input logic a, input logic k);
      @(negedge clk);
      bus.start = s;
      bus.abort = a;
      bus.ack   = k;
   endtask

   // Pulse start and confirm the load cycle at the sampling edge.
   task automatic startBlock(input string nm);
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      checkOutput({nm, "_load"}, {bus.sel, bus.round, bus.done}, {1'b1, 4'd0, 1'b0});
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic waitDone(input string nm, output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #2;
         cyc++;
      end while (bus.done !== 1'b1 && cyc < 40);
      if (bus.done !== 1'b1) checkOutput({nm, "_done_timeout"}, {31'd0, bus.done}, 32'd1);
   endtask

   task automatic waitRound(input string nm, input int k);
      int c;
      c = 0;
      while (bus.round !== CW'(k) && c < 20) begin
         @(posedge clk);
         #2;
         c++;
      end
      if (bus.round !== CW'(k)) checkOutput({nm, "_round_timeout"}, {28'd0, bus.round}, k);
   endtask

   task automatic ackResult(input string nm);
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #2;
      checkOutput({nm, "_ack_idle"}, {bus.done, bus.busy, bus.round}, 6'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.ack   = 1'b0;

      // Reset then idle
      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset_outputs", dutVec, 0);
      cmpEn = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      checkOutput("idle_20_cycles", dutVec, 0);

      // Single block with ack held low
      clearCounts();
      startBlock("single");
      for (int k = 1; k <= ROUNDS; k++) begin
         @(posedge clk);
         #2;
         checkOutput("single_round_idx", {28'd0, bus.round}, k);
         checkOutput("single_last", {31'd0, bus.last}, (k == ROUNDS) ? 32'd1 : 32'd0);
      end
      @(posedge clk);
      #2;
      checkOutput("single_done_12", {bus.done, bus.last, bus.round}, {1'b1, 1'b0, 4'd10});
      repeat (30) @(posedge clk);
      #2;
      checkOutput("single_done_held", {bus.done, bus.busy}, 2'b11);
      checkOutput("single_reg_en_cnt", regEnCnt, 11);
      checkOutput("single_key_en_cnt", keyEnCnt, 10);
      checkOutput("single_sel_cnt", selCnt, 1);
      checkOutput("single_done_rises", doneRise, 1);
      ackResult("single");

      // Back-to-back blocks
      startBlock("b2b1");
      waitDone("b2b1", c);
      checkOutput("b2b1_latency", c, 11);
      clearCounts();
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(posedge clk);
      #2;
      checkOutput("b2b_reload", {bus.sel, bus.round, bus.done}, {1'b1, 4'd0, 1'b0});
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitDone("b2b2", c);
      checkOutput("b2b2_latency", c, 11);
      checkOutput("b2b2_reg_en_cnt", regEnCnt, 11);
      checkOutput("b2b2_key_en_cnt", keyEnCnt, 10);
      checkOutput("b2b2_sel_cnt", selCnt, 1);
      ackResult("b2b2");

      // Start during rounds is ignored
      clearCounts();
      startBlock("ign");
      waitRound("ign", 5);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitDone("ign", c);
      repeat (5) @(posedge clk);
      #2;
      checkOutput("ign_done_rises", doneRise, 1);
      checkOutput("ign_reg_en_cnt", regEnCnt, 11);
      checkOutput("ign_round_hold", {28'd0, bus.round}, 10);
      ackResult("ign");

      // Abort at round 7, then a fresh full block
      startBlock("abort");
      waitRound("abort", 7);
      applyStimulus(1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      checkOutput("abort_outputs", dutVec, 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      clearCounts();
      startBlock("fresh");
      waitDone("fresh", c);
      checkOutput("fresh_latency", c, 11);
      checkOutput("fresh_reg_en_cnt", regEnCnt, 11);
      ackResult("fresh");

      // Asynchronous reset between edges at round 4
      startBlock("arst");
      waitRound("arst", 4);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_outputs", dutVec, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      checkOutput("post_reset_idle", dutVec, 0);
      startBlock("after_rst");
      waitDone("after_rst", c);
      checkOutput("after_rst_latency", c, 11);
      ackResult("after_rst");

      repeat (3) @(posedge clk);
      #3;
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
